// File: rtl/fetch_pc_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pc_gen_if
// Description : Bundle of request inputs (stall, predict, redirect) and
//               fetch-group outputs of the fetch-stage PC generator.
//               FETCH_PC_GEN_PERF_EN adds the three performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_pc_gen_if #(
   parameter int XLEN        = 32,
   parameter int FETCH_WIDTH = 2
);
   logic                   stall_i;
   logic                   predict_valid_i;
   logic [XLEN-1:0]        predict_pc_i;
   logic                   redirect_valid_i;
   logic [XLEN-1:0]        redirect_pc_i;
   logic [XLEN-1:0]        pc_o;
   logic                   valid_o;
   logic [FETCH_WIDTH-1:0] slot_mask_o;
   logic                   misalign_o;
`ifdef FETCH_PC_GEN_PERF_EN
   logic [31:0]            perf_redirects_o;
   logic [31:0]            perf_predicts_o;
   logic [31:0]            perf_stalls_o;
`endif

   // PC generator side
   modport slave (
      input  stall_i, predict_valid_i, predict_pc_i, redirect_valid_i, redirect_pc_i,
`ifdef FETCH_PC_GEN_PERF_EN
      output perf_redirects_o, perf_predicts_o, perf_stalls_o,
`endif
      output pc_o, valid_o, slot_mask_o, misalign_o
   );

   // Requesting / consuming side
   modport master (
      output stall_i, predict_valid_i, predict_pc_i, redirect_valid_i, redirect_pc_i,
`ifdef FETCH_PC_GEN_PERF_EN
      input  perf_redirects_o, perf_predicts_o, perf_stalls_o,
`endif
      input  pc_o, valid_o, slot_mask_o, misalign_o
   );
endinterface
`default_nettype wire

// File: rtl/fetch_pc_gen.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pc_gen
// Description : Fetch-stage program-counter generator. Emits one aligned
//               fetch-group address per cycle with a per-slot valid mask.
//               Priority: back-end redirect > stall > predict > sequential.
//               Optional macro FETCH_PC_GEN_PERF_EN adds saturating counters
//               for accepted redirects, accepted predicts and stall cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_pc_gen #(
   parameter int              XLEN         = 32,
   parameter int              FETCH_WIDTH  = 2,
   parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
   input  wire logic           clock_i,
   input  wire logic           reset_i,
   fetch_pc_gen_if.slave       bus
);

   localparam int              c_gb      = 4 * FETCH_WIDTH;
   localparam logic [XLEN-1:0] c_gb_x    = XLEN'(c_gb);
   localparam logic [XLEN-1:0] c_lo_mask = XLEN'(c_gb - 1);
   localparam logic [XLEN-1:0] c_slot_m  = XLEN'(FETCH_WIDTH - 1);

   typedef enum logic [0:0] {
      BOOT = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t                 r_state;
   logic [XLEN-1:0]        r_pc;
   logic                   r_valid;
   logic [FETCH_WIDTH-1:0] r_mask;
   logic                   r_misalign;

   logic                   w_take_redirect;
   logic                   w_take_predict;
   logic                   w_hold;
   logic [XLEN-1:0]        w_target;

   // Slot mask for an entry address: slots below the entry slot are dead.
   // The slot field is bits [OFS-1:2]; for a single-slot group it is empty.
   function automatic logic [FETCH_WIDTH-1:0] f_mask(input logic [XLEN-1:0] addr);
      logic [FETCH_WIDTH-1:0] m;
      int                     slot;
      m    = '0;
      slot = int'((addr >> 2) & c_slot_m);
      for (int i = 0; i < FETCH_WIDTH; i++) begin
         m[i] = (i >= slot);
      end
      return m;
   endfunction

   // Next-pc source selection; a redirect overrides a stall, a stall drops a predict
   always_comb begin
      w_take_redirect = (r_state == RUN) && bus.redirect_valid_i;
      w_hold          = (r_state == RUN) && !bus.redirect_valid_i && bus.stall_i;
      w_take_predict  = (r_state == RUN) && !bus.redirect_valid_i && !bus.stall_i
                        && bus.predict_valid_i;
      w_target        = bus.redirect_valid_i ? bus.redirect_pc_i : bus.predict_pc_i;
   end

   // Boot/run state machine with registered fetch-group outputs
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         r_state    <= BOOT;
         r_pc       <= RESET_VECTOR;
         r_valid    <= 1'b0;
         r_mask     <= '0;
         r_misalign <= 1'b0;
      end else begin
         case (r_state)
            BOOT: begin
               r_state    <= RUN;
               r_valid    <= 1'b1;
               r_mask     <= f_mask(RESET_VECTOR);
               r_misalign <= 1'b0;
            end
            default: begin
               r_misalign <= 1'b0;
               if (w_take_redirect || w_take_predict) begin
                  r_pc       <= {w_target[XLEN-1:2], 2'b00};
                  r_mask     <= f_mask(w_target);
                  r_misalign <= (w_target[1:0] != 2'b00);
               end else if (!w_hold) begin
                  r_pc   <= (r_pc & ~c_lo_mask) + c_gb_x;
                  r_mask <= '1;
               end
            end
         endcase
      end
   end

   assign bus.pc_o        = r_pc;
   assign bus.valid_o     = r_valid;
   assign bus.slot_mask_o = r_mask;
   assign bus.misalign_o  = r_misalign;

`ifdef FETCH_PC_GEN_PERF_EN
   logic [31:0] r_perf_redirects;
   logic [31:0] r_perf_predicts;
   logic [31:0] r_perf_stalls;

   // Saturating event counters; stall cycles exclude those overridden by a redirect
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         r_perf_redirects <= '0;
         r_perf_predicts  <= '0;
         r_perf_stalls    <= '0;
      end else begin
         if (w_take_redirect && (r_perf_redirects != 32'hFFFF_FFFF))
            r_perf_redirects <= r_perf_redirects + 32'd1;
         if (w_take_predict && (r_perf_predicts != 32'hFFFF_FFFF))
            r_perf_predicts <= r_perf_predicts + 32'd1;
         if (w_hold && (r_perf_stalls != 32'hFFFF_FFFF))
            r_perf_stalls <= r_perf_stalls + 32'd1;
      end
   end

   assign bus.perf_redirects_o = r_perf_redirects;
   assign bus.perf_predicts_o  = r_perf_predicts;
   assign bus.perf_stalls_o    = r_perf_stalls;
`endif

endmodule
`default_nettype wire
